// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and shift-mode helpers for the execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_mode_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic shift_mode_e shift_mode_of(input logic [3:0] op);
    case (op)
      ALU_SRL: return SH_RL;
      ALU_SRA: return SH_RA;
      default: return SH_LL;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle between the issue stage (master) and the ALU (slave).
interface alu_exec_unit_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control_lines;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            flag_err;

  modport master (
    output in_valid, alu_control_lines, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, flag_err
  );

  modport slave (
    input  in_valid, alu_control_lines, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, flag_err
  );
endinterface

// File: rtl/alu_shift_iter.sv
// One-bit-per-cycle shifter: loads on start_i, shifts while the down-counter is non-zero.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [4:0]      shamt_i,
  input  shift_mode_e     mode_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] work_q, work_d, work_shift;
  logic [4:0]      cnt_q, cnt_d;
  shift_mode_e     mode_q, mode_d;

  always_comb begin
    case (mode_q)
      SH_RL:   work_shift = work_q >> 1;
      SH_RA:   work_shift = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: work_shift = work_q << 1;
    endcase

    work_d = work_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (start_i) begin
      work_d = data_i;
      cnt_d  = shamt_i;
      mode_d = mode_i;
    end else if (cnt_q != 5'd0) begin
      work_d = work_shift;
      cnt_d  = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      cnt_q  <= 5'd0;
      mode_q <= SH_LL;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  // The final shift is handed out combinationally so the top can register it on this same edge.
  assign done_o   = (cnt_q == 5'd1);
  assign result_o = work_shift;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative shifts, registered result/zero/err.
// state | meaning
// IDLE  | waiting for an op, in_ready=1
// SHIFT | iterative shift in flight
// DONE  | result held, out_valid=1 until out_ready
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  alu_exec_unit_if.slave bus
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] alu_res, sh_result;
  logic            alu_undef, accept, sh_start, sh_done, shift_multi;
  logic [3:0]      op;

  assign op          = bus.alu_control_lines;
  assign shift_multi = is_shift_op(op) && (bus.op_b[4:0] != 5'd0);

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.flag_err  = err_q;
  assign accept        = bus.in_valid && bus.in_ready;

  always_comb begin
    alu_res   = '0;
    alu_undef = 1'b0;
    case (op)
      ALU_AND: alu_res = bus.op_a & bus.op_b;
      ALU_OR:  alu_res = bus.op_a | bus.op_b;
      ALU_ADD: alu_res = bus.op_a + bus.op_b;
      ALU_SUB: alu_res = bus.op_a - bus.op_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      ALU_NOR: alu_res = ~(bus.op_a | bus.op_b);
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = bus.op_a;
      default: alu_undef = 1'b1;
    endcase
  end

  alu_shift_iter #(.XLEN(XLEN)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .start_i  (sh_start),
    .data_i   (bus.op_a),
    .shamt_i  (bus.op_b[4:0]),
    .mode_i   (shift_mode_of(op)),
    .done_o   (sh_done),
    .result_o (sh_result)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    sh_start = 1'b0;

    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (sh_done) begin
          result_d = sh_result;
          zero_d   = (sh_result == '0);
          err_d    = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready && !bus.in_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accept covers both IDLE and the DONE-with-out_ready overlap, giving 1 op/cycle throughput.
    if (accept) begin
      if (shift_multi) begin
        sh_start = 1'b1;
        state_d  = SHIFT;
      end else begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        err_d    = alu_undef;
        state_d  = DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   lat;

  alu_exec_unit_if #(.XLEN(32)) bus ();

  alu_exec_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.alu_control_lines = op;
    bus.op_a              = a;
    bus.op_b              = b;
    bus.in_valid          = 1'b1;
  endtask

  // Counts cycles from the accepting edge until out_valid, giving up after 40.
  task automatic wait_out(output int n);
    n = 1;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  logic [3:0]  v_op [4];
  logic [31:0] v_a  [4];
  logic [31:0] v_b  [4];
  logic [31:0] v_r  [4];

  initial begin
    v_op = '{ALU_OR,       ALU_NOR,      ALU_SLT,      ALU_SUB};
    v_a  = '{32'h0F0F0000, 32'h00000000, 32'h00000001, 32'h00000000};
    v_b  = '{32'h000000F0, 32'h00000000, 32'hFFFFFFFF, 32'h00000001};
    v_r  = '{32'h0F0F00F0, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};

    rst                   = 1'b1;
    bus.in_valid          = 1'b0;
    bus.out_ready         = 1'b0;
    bus.alu_control_lines = 4'b0000;
    bus.op_a              = '0;
    bus.op_b              = '0;
    step();
    step();
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result",    bus.result,             32'd0);
    check("rst_zero",      {31'd0, bus.zero},      32'd1);
    check("rst_flag_err",  {31'd0, bus.flag_err},  32'd0);
    rst = 1'b0;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);

    // Reset in the middle of a 20-bit left shift
    bus.out_ready = 1'b1;
    drive(ALU_SLL, 32'h00000001, 32'd20);
    step();
    bus.in_valid = 1'b0;
    check("shift_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("shift_out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (4) step();
    check("mid_shift_busy",  {31'd0, bus.out_valid}, 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_result",    bus.result,             32'd0);
    check("midrst_zero",      {31'd0, bus.zero},      32'd1);
    step();
    rst = 1'b0;
    step();
    check("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("midrst_idle",      {31'd0, bus.out_valid}, 32'd0);

    // ADD then SUB back-to-back
    drive(ALU_ADD, 32'h7FFFFFFF, 32'h00000001);
    step();
    check("add_result",    bus.result,             32'h80000000);
    check("add_zero",      {31'd0, bus.zero},      32'd0);
    check("add_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("add_in_ready",  {31'd0, bus.in_ready},  32'd1);
    drive(ALU_SUB, 32'd5, 32'd5);
    step();
    check("sub_result",    bus.result,             32'd0);
    check("sub_zero",      {31'd0, bus.zero},      32'd1);
    check("sub_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("sub_in_ready",  {31'd0, bus.in_ready},  32'd1);
    bus.in_valid = 1'b0;
    step();
    check("b2b_drained", {31'd0, bus.out_valid}, 32'd0);

    // Streamed single-cycle ops
    for (int i = 0; i < 4; i++) begin
      drive(v_op[i], v_a[i], v_b[i]);
      step();
      check($sformatf("stream%0d_result", i), bus.result, v_r[i]);
      check($sformatf("stream%0d_zero", i), {31'd0, bus.zero}, {31'd0, (v_r[i] == 32'd0)});
    end
    bus.in_valid = 1'b0;
    step();

    drive(ALU_SLT, 32'hFFFFFFFF, 32'h00000001);
    step();
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("slt_latency", lat,        32'd1);
    check("slt_result",  bus.result, 32'd1);
    step();

    drive(ALU_SRA, 32'h80000000, 32'd4);
    step();
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("sra_latency", lat,        32'd5);
    check("sra_result",  bus.result, 32'hF8000000);
    step();

    drive(ALU_SRL, 32'h80000000, 32'd31);
    step();
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("srl_latency", lat,        32'd32);
    check("srl_result",  bus.result, 32'h00000001);
    step();

    // Upper op_b bits must not leak into the shift amount
    drive(ALU_SLL, 32'h12345678, 32'h00000020);
    step();
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("sll0_latency", lat,        32'd1);
    check("sll0_result",  bus.result, 32'h12345678);
    step();

    // Backpressure: result held, new op refused
    bus.out_ready = 1'b0;
    drive(ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00);
    step();
    drive(ALU_ADD, 32'd1, 32'd1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp%0d_result", i),    bus.result,             32'hF000F000);
      check($sformatf("bp%0d_out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("bp%0d_in_ready", i),  {31'd0, bus.in_ready},  32'd0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("bp_released",   {31'd0, bus.out_valid}, 32'd0);
    check("bp_not_taken",  bus.result,             32'hF000F000);

    drive(4'b1111, 32'h00001234, 32'h00005678);
    step();
    bus.in_valid = 1'b0;
    check("undef_err",       {31'd0, bus.flag_err},  32'd1);
    check("undef_result",    bus.result,             32'd0);
    check("undef_zero",      {31'd0, bus.zero},      32'd1);
    check("undef_out_valid", {31'd0, bus.out_valid}, 32'd1);
    drive(ALU_ADD, 32'd3, 32'd4);
    step();
    bus.in_valid = 1'b0;
    check("after_undef_err",    {31'd0, bus.flag_err}, 32'd0);
    check("after_undef_result", bus.result,            32'd7);
    check("after_undef_zero",   {31'd0, bus.zero},     32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 4-bit `alu_control_lines` code produced by the ALU control decoder, together with two operands, and returns a registered result, zero flag and error flag. It uses a valid/ready handshake on both sides so the pipeline can stall. Logic ops and add/sub complete in one cycle. Shifts are computed iteratively, one bit per cycle, to keep the barrel shifter out of the critical path.

## Interface
- `XLEN`, 32: operand and result width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `in_valid`  in  1: operation presented.
- `in_ready`  out  1: unit can accept an operation this cycle.
- `alu_control_lines`  in  4: operation code.
- `op_a`  in  XLEN: first operand.
- `op_b`  in  XLEN: second operand; `op_b[4:0]` is the shift amount.
- `out_valid`  out  1: result registers hold a completed operation.
- `out_ready`  in  1: consumer accepts the result.
- `result`  out  XLEN: operation result.
- `zero`  out  1: `result == 0`.
- `flag_err`  out  1: opcode was undefined.

## Operation
- Opcodes:
  - `0000` AND
  - `0001` OR
  - `0010` ADD
  - `0110` SUB
  - `0111` SLT (signed, result 1 or 0)
  - `1100` NOR
  - `0011` SLL
  - `0100` SRL
  - `0101` SRA
- Any other code: `result = 0`, `zero = 1`, `flag_err = 1`, completing like a single-cycle op.
- ADD and SUB wrap modulo 2^XLEN; no overflow output.
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid`, a non-shift op, or a shift with shamt 0, writes its result into the output registers and goes to DONE.
  - A shift with shamt k > 0 loads `op_a`, the op and k into working registers and goes to SHIFT.
- SHIFT:
  - Each cycle shifts the working value one bit: left with zero fill, right with zero fill, or right copying the sign bit. It then decrements the counter.
  - On the cycle the counter reaches 1, the final value goes into `result` and the state goes to DONE.
- DONE:
  - `out_valid = 1`; `result`, `zero` and `flag_err` are held stable until `out_ready`.
  - On `out_ready` without `in_valid`, go to IDLE.
- `in_ready = (state == IDLE) || (state == DONE && out_ready)`.
- Simultaneous DONE, `out_ready` and `in_valid`: the old result is consumed and the new op is accepted in the same cycle. The next state is DONE or SHIFT, as from IDLE, so back-to-back single-cycle ops sustain 1 op per cycle.
- Inputs are ignored while `in_ready = 0`.
- `flag_err` is cleared for every accepted defined opcode; it never persists across operations.

## Timing
- Reset (asynchronous, any state, including mid-shift):
  - state goes to IDLE.
  - `out_valid = 0`, `result = 0`, `zero = 1`, `flag_err = 0`.
  - Shift counter and working registers are cleared; any in-flight op is discarded.
- `in_ready` is 1 in the first cycle after reset deasserts.
- Latency from the accepting edge to `out_valid` high:
  - Non-shift op or shamt 0: 1 cycle.
  - Shift with shamt k: 1 + k cycles (maximum 32).
- `zero` is registered together with `result`, never combinational from the inputs.
- `in_ready` and `out_valid` are never both low after reset except in SHIFT.

## Structure
- Shared package `alu_pkg` holds:
  - Opcode localparams: `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_NOR`, `ALU_SLL`, `ALU_SRL`, `ALU_SRA`.
  - State encoding: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
  - The ALU control decoder uses the same opcode constants.
- One sub-module, `alu_shift_iter`:
  - Holds the working register, the 5-bit down-counter and the direction/arith select.
  - Interface: start/done handshake.
- The top level holds the FSM, the single-cycle datapath and the output registers.

## Test plan
- Reset mid-shift: start SLL with shamt 20, assert `rst` after 5 cycles -> `out_valid = 0`, `result = 0`, `zero = 1`, `in_ready = 1` one cycle after release.
- ADD 0x7FFF_FFFF + 1, then SUB 5 - 5, back-to-back with `out_ready` held 1 -> results 0x8000_0000 (`zero = 0`), then 0 (`zero = 1`), on consecutive cycles; `in_ready` stays 1.
- SLT 0xFFFF_FFFF vs 1 -> result 1.
- SRA 0x8000_0000 by 4 -> 0xF800_0000, `out_valid` exactly 5 cycles after accept.
- SRL 0x8000_0000 by 31 -> 0x0000_0001 after 32 cycles.
- SLL by 0 -> result equals `op_a` after 1 cycle.
- Backpressure: hold `out_ready = 0` for 10 cycles after AND 0xF0F0_F0F0 & 0xFF00_FF00 -> `result = 0xF000_F000` stable throughout, `in_ready = 0`, and a new `in_valid` is not accepted.
- Undefined opcode `1111` -> `flag_err = 1`, `result = 0`, `zero = 1` after 1 cycle; a following ADD clears `flag_err`.
